kyber_hash_sequencer: RTL and testbench

- Controller that time-shares one external SHA3 core across the three hashes of Kyber encapsulation pre-processing.
- Job order: m = H(rand_in); h = H(ek); (pre_k, coin) = G(m || h).
- Sits between the encaps top-level FSM and the shared Keccak/SHA3 core, replacing three dedicated hash instances.
- Caches H(ek) so repeated encapsulations under the same key skip the 1184-byte hash.

---
 rtl/kyber_pkg.sv | 26 ++
 rtl/hash_job_timer.sv | 26 ++
 rtl/kyber_hash_sequencer.sv | 135 +++++++++++++
 tb/tb_kyber_hash_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber widths, SHA3 core job modes and hash sequencer states.
package kyber_pkg;

  localparam int KYBER_N       = 256;
  localparam int KYBER_K       = 3;
  localparam int KYBER_R_WIDTH = 12;
  localparam int EK_W          = KYBER_N + KYBER_K * KYBER_R_WIDTH * KYBER_N;

  typedef enum logic [1:0] {
    SHA_256_SHORT = 2'd0,
    SHA_256_EK    = 2'd1,
    SHA_512       = 2'd2
  } core_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_M,
    WAIT_M,
    ISSUE_EK,
    WAIT_EK,
    ISSUE_G,
    WAIT_G,
    DONE
  } seq_state_t;

endpackage

// File: rtl/hash_job_timer.sv
// rtl/hash_job_timer.sv - Per-job wait counter; flags the last allowed wait cycle.
module hash_job_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Leaving the wait state drops run, so the count restarts at every new job.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/kyber_hash_sequencer.sv
// rtl/kyber_hash_sequencer.sv - Time-shares one SHA3 core across H(m), H(ek) and G(m||h),
// caching H(ek) across passes under an unchanged key.
module kyber_hash_sequencer
  import kyber_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ek_same,
  input  logic [KYBER_N-1:0]   rand_in,
  input  logic [EK_W-1:0]      encryption_key,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [KYBER_N-1:0]   msg,
  output logic [KYBER_N-1:0]   hash_ek,
  output logic [KYBER_N-1:0]   pre_k,
  output logic [KYBER_N-1:0]   coin,
  output logic                 core_start,
  output logic [1:0]           core_mode,
  output logic [EK_W-1:0]      core_din,
  input  logic                 core_ready,
  input  logic                 core_valid,
  input  logic [511:0]         core_dout
);

  seq_state_t         state, state_next;
  core_mode_t         mode;
  logic [KYBER_N-1:0] rand_q;
  logic               skip_ek;
  logic               ek_cache_valid;
  logic               in_wait;
  logic               expired;
  logic               timeout;

  hash_job_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (in_wait),
    .expired (expired)
  );

  assign in_wait = (state == WAIT_M) || (state == WAIT_EK) || (state == WAIT_G);
  // A digest arriving on the terminal count still wins over the timeout.
  assign timeout = expired && !core_valid;

  assign busy      = (state != IDLE) && (state != DONE) && !timeout;
  assign done      = (state == DONE);
  assign error     = timeout;
  assign core_mode = mode;

  always_comb begin
    state_next = state;
    mode       = SHA_256_SHORT;
    core_din   = '0;
    core_start = 1'b0;
    case (state)
      IDLE: if (start) state_next = ISSUE_M;
      ISSUE_M: begin
        core_din[KYBER_N-1:0] = rand_q;
        if (core_ready) begin
          core_start = 1'b1;
          state_next = WAIT_M;
        end
      end
      WAIT_M: begin
        if (core_valid)   state_next = skip_ek ? ISSUE_G : ISSUE_EK;
        else if (expired) state_next = IDLE;
      end
      ISSUE_EK: begin
        mode     = SHA_256_EK;
        core_din = encryption_key;
        if (core_ready) begin
          core_start = 1'b1;
          state_next = WAIT_EK;
        end
      end
      WAIT_EK: begin
        if (core_valid)   state_next = ISSUE_G;
        else if (expired) state_next = IDLE;
      end
      ISSUE_G: begin
        mode                    = SHA_512;
        core_din[2*KYBER_N-1:0] = {hash_ek, msg};
        if (core_ready) begin
          core_start = 1'b1;
          state_next = WAIT_G;
        end
      end
      WAIT_G: begin
        if (core_valid)   state_next = DONE;
        else if (expired) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rand_q         <= '0;
      skip_ek        <= 1'b0;
      ek_cache_valid <= 1'b0;
      msg            <= '0;
      hash_ek        <= '0;
      pre_k          <= '0;
      coin           <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        rand_q  <= rand_in;
        skip_ek <= ek_same && ek_cache_valid;
      end
      if (core_valid) begin
        case (state)
          WAIT_M: msg <= core_dout[KYBER_N-1:0];
          WAIT_EK: begin
            hash_ek        <= core_dout[KYBER_N-1:0];
            ek_cache_valid <= 1'b1;
          end
          WAIT_G: begin
            pre_k <= core_dout[KYBER_N-1:0];
            coin  <= core_dout[2*KYBER_N-1:KYBER_N];
          end
          default: ;
        endcase
      end
      if (timeout) ek_cache_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kyber_hash_sequencer.sv
// tb/tb_kyber_hash_sequencer.sv - Scoreboard bench with a behavioural SHA3 core stand-in.
module tb_kyber_hash_sequencer;
  import kyber_pkg::*;

  localparam int TO = 32;
  localparam logic [255:0] C0 = {8{32'hA5C3_0F17}};
  localparam logic [255:0] C1 = {8{32'h3C96_E1B4}};
  localparam logic [255:0] C2 = {8{32'h7F00_5AA5}};

  logic               clk = 1'b0;
  logic               rst, start, ek_same, core_ready, core_valid;
  logic [KYBER_N-1:0] rand_in, msg, hash_ek, pre_k, coin;
  logic [EK_W-1:0]    encryption_key, core_din;
  logic               busy, done, error, core_start;
  logic [1:0]         core_mode;
  logic [511:0]       core_dout;

  kyber_hash_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .ek_same(ek_same), .rand_in(rand_in),
    .encryption_key(encryption_key), .busy(busy), .done(done), .error(error),
    .msg(msg), .hash_ek(hash_ek), .pre_k(pre_k), .coin(coin),
    .core_start(core_start), .core_mode(core_mode), .core_din(core_din),
    .core_ready(core_ready), .core_valid(core_valid), .core_dout(core_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in digest: cheap, distinct per mode, sensitive to every din bit of its job.
  function automatic logic [511:0] fake_hash(input logic [1:0] m, input logic [EK_W-1:0] din);
    logic [255:0] a, b;
    a = din[255:0];
    b = '0;
    case (m)
      2'd0: return {~a, {a[127:0], a[255:128]} ^ C0};
      2'd1: begin
        for (int i = 0; i < EK_W / 256; i++) b ^= din[i*256 +: 256];
        return {~b, b ^ C1};
      end
      default: return {din[255:0] ^ C2, din[511:256] + din[255:0]};
    endcase
  endfunction

  int           lat        = 24;
  bit           drop_g     = 1'b0;
  bit           stall_on_m = 1'b0;
  int           stall      = 0;
  bit           pend       = 1'b0;
  int           due        = 0;
  logic [1:0]   pend_mode  = 2'd0;
  logic [511:0] res        = '0;
  int           n_starts   = 0;

  always @(negedge clk) begin
    core_valid = 1'b0;
    if (stall > 0) begin
      stall--;
      if (stall == 0) core_ready = 1'b1;
    end
    if (pend && cyc + 1 == due) begin
      core_valid = 1'b1;
      core_dout  = res;
      pend       = 1'b0;
      if (stall_on_m && pend_mode == 2'd0) begin
        core_ready = 1'b0;
        stall      = 11;
        stall_on_m = 1'b0;
      end
    end
    #1;
    if (core_start && core_ready) begin
      n_starts++;
      if (core_mode == 2'd0) chk("din_ext_m", {255'b0, |core_din[EK_W-1:256]}, 256'd0);
      if (core_mode == 2'd2) chk("din_ext_g", {255'b0, |core_din[EK_W-1:512]}, 256'd0);
      if (!(drop_g && core_mode == 2'd2)) begin
        pend      = 1'b1;
        due       = cyc + 1 + lat;
        pend_mode = core_mode;
        res       = fake_hash(core_mode, core_din);
      end
    end
  end

  typedef struct {
    bit           is_err;
    int           end_edge;
    logic [255:0] m, h, p, c;
    int           starts;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    #2;
    if (!rst && (done || error)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_end: done=%0b error=%0b expected no pass in flight", done, error);
      end else begin
        e = sb.pop_front();
        chk("done_flag", {255'b0, done}, {255'b0, !e.is_err});
        chk("error_flag", {255'b0, error}, {255'b0, e.is_err});
        chk("end_edge", cyc + 1, e.end_edge);
        chk("busy_at_end", {255'b0, busy}, 256'd0);
        chk("core_starts", n_starts, e.starts);
        chk("msg", msg, e.m);
        chk("hash_ek", hash_ek, e.h);
        chk("pre_k", pre_k, e.p);
        chk("coin", coin, e.c);
      end
    end
  end

  bit           m_cache = 1'b0;
  logic [255:0] m_hek = '0, m_pk = '0, m_coin = '0;

  task automatic run_pass(input logic [255:0] r, input bit same, input int extra,
                          input bit expect_err, input bit poke);
    exp_t         x;
    logic [511:0] t;
    logic [255:0] em;
    bit           skip;
    int           tstart;
    skip = same && m_cache;
    t    = fake_hash(2'd0, EK_W'(r));
    em   = t[255:0];
    if (!skip) begin
      t       = fake_hash(2'd1, encryption_key);
      m_hek   = t[255:0];
      m_cache = 1'b1;
    end
    t = fake_hash(2'd2, EK_W'({m_hek, em}));
    @(negedge clk);
    rand_in = r;
    ek_same = same;
    start   = 1'b1;
    tstart  = cyc + 1;
    x.is_err = expect_err;
    x.m      = em;
    x.h      = m_hek;
    x.starts = skip ? 2 : 3;
    if (expect_err) begin
      x.end_edge = tstart + (skip ? 2 + lat : 3 + 2 * lat) + extra + TO;
      m_cache    = 1'b0;
    end else begin
      x.end_edge = tstart + (skip ? 3 + 2 * lat : 4 + 3 * lat) + extra;
      m_pk       = t[255:0];
      m_coin     = t[511:256];
    end
    x.p = m_pk;
    x.c = m_coin;
    n_starts = 0;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {255'b0, busy}, 256'd1);
    if (poke) begin
      repeat (8) @(negedge clk);
      rand_in = ~r;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL pass_timeout: no done/error within 400 cycles, %0d pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_msg"}, msg, 256'd0);
    chk({tag, "_hash_ek"}, hash_ek, 256'd0);
    chk({tag, "_pre_k"}, pre_k, 256'd0);
    chk({tag, "_coin"}, coin, 256'd0);
    chk({tag, "_flags"}, {249'b0, busy, done, error, core_start, core_mode, |core_din}, 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [255:0] ra;
    int           t0;
    rst        = 1'b1;
    start      = 1'b0;
    ek_same    = 1'b0;
    rand_in    = '0;
    core_ready = 1'b1;
    core_valid = 1'b0;
    core_dout  = '0;
    for (int i = 0; i < EK_W / 32; i++) encryption_key[i*32 +: 32] = (32'h9E37_79B9 * (i + 1)) ^ i;
    for (int i = 0; i < 32; i++) ra[i*8 +: 8] = 8'(i + 1);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    run_pass(ra, 1'b1, 0, 1'b0, 1'b0);
    run_pass({8{32'hDEAD_BEEF}}, 1'b0, 0, 1'b0, 1'b1);
    run_pass({8{32'h0123_4567}}, 1'b1, 0, 1'b0, 1'b0);
    stall_on_m = 1'b1;
    run_pass({8{32'h89AB_CDEF}}, 1'b0, 10, 1'b0, 1'b0);
    lat = TO;
    run_pass({8{32'h5555_AAAA}}, 1'b0, 0, 1'b0, 1'b0);
    lat = 24;
    drop_g = 1'b1;
    run_pass({8{32'hC001_D00D}}, 1'b0, 0, 1'b1, 1'b0);
    drop_g = 1'b0;
    run_pass({8{32'hF00D_FACE}}, 1'b1, 0, 1'b0, 1'b0);

    @(negedge clk);
    rand_in = {8{32'h1357_9BDF}};
    ek_same = 1'b0;
    start   = 1'b1;
    t0      = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc + 1 < t0 + 2 + lat + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    @(negedge clk);
    chk_zero("mid_reset2");
    rst     = 1'b0;
    m_cache = 1'b0;
    m_hek   = '0;
    m_pk    = '0;
    m_coin  = '0;
    while (cyc + 1 < t0 + 2 * lat + 3) @(negedge clk);
    chk_zero("orphan");
    run_pass({8{32'h2468_ACE0}}, 1'b1, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
